// File: rtl/s_axi4l_arb_pkg.sv
// Shared types for the AXI4-Lite register-bank arbiter: FSM state encoding
// and the grant identifiers stored in last_grant.
package s_axi4l_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD      = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } arb_state_t;

  localparam logic GNT_RD = 1'b0;
  localparam logic GNT_WR = 1'b1;

  // Bit positions inside the one-hot grant vector from rr_arb2
  localparam int GNT_BIT_RD = 0;
  localparam int GNT_BIT_WR = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie the requester that did not win
// last time is chosen. Purely combinational; last_grant lives in the parent.
module rr_arb2
  import s_axi4l_arb_pkg::*;
(
  input  logic       i_req_rd,
  input  logic       i_req_wr,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req_rd && i_req_wr) begin
      if (i_last_grant == GNT_WR) o_gnt[GNT_BIT_RD] = 1'b1;
      else                        o_gnt[GNT_BIT_WR] = 1'b1;
    end else if (i_req_rd) begin
      o_gnt[GNT_BIT_RD] = 1'b1;
    end else if (i_req_wr) begin
      o_gnt[GNT_BIT_WR] = 1'b1;
    end
  end

endmodule

// File: rtl/s_axi4l_regbank_arbiter.sv
// Shares one single-port register bank between the AXI4-Lite read and write
// channels. Optional address range check: S_AXI4L_ARB_RANGE_CHECK_EN.
module s_axi4l_regbank_arbiter
  import s_axi4l_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8,
  parameter int NUM_REGS       = 4
) (
  input  logic                      i_axi_clock,
  input  logic                      i_axi_reset,
  input  logic                      i_rd_req,
  input  logic [AXI_ADDR_WIDTH-1:0] i_rd_addr,
  output logic                      o_rd_gnt,
  output logic [AXI_DATA_WIDTH-1:0] o_rd_data,
  output logic                      o_rd_data_valid,
  output logic                      o_rd_err,
  input  logic                      i_wr_req,
  input  logic [AXI_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_wr_data,
  input  logic [AXI_STRB_WIDTH-1:0] i_wr_strb,
  output logic                      o_wr_gnt,
  output logic                      o_wr_done,
  output logic                      o_wr_err,
  output logic                      o_reg_en,
  output logic                      o_reg_we,
  output logic [AXI_ADDR_WIDTH-1:0] o_reg_addr,
  output logic [AXI_DATA_WIDTH-1:0] o_reg_wdata,
  output logic [AXI_STRB_WIDTH-1:0] o_reg_wstrb,
  input  logic [AXI_DATA_WIDTH-1:0] i_reg_rdata
);

  arb_state_t                r_state;
  arb_state_t                w_next_state;
  logic                      r_last_grant;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [AXI_STRB_WIDTH-1:0] r_wstrb;
  logic [AXI_DATA_WIDTH-1:0] r_rd_data;
  logic                      r_rd_valid;
  logic                      r_rd_err;
  logic                      r_wr_done;
  logic                      r_wr_err;
  logic [1:0]                w_gnt;
  logic                      w_rd_gnt;
  logic                      w_wr_gnt;
  logic                      w_in_range;

  rr_arb2 u_rr_arb2 (
    .i_req_rd     (i_rd_req),
    .i_req_wr     (i_wr_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  // Requests are only honoured while the bank port is free
  assign w_rd_gnt = (r_state == IDLE) && w_gnt[GNT_BIT_RD];
  assign w_wr_gnt = (r_state == IDLE) && w_gnt[GNT_BIT_WR];

`ifdef S_AXI4L_ARB_RANGE_CHECK_EN
  assign w_in_range = int'(r_addr[AXI_ADDR_WIDTH-1:2]) < NUM_REGS;
`else
  assign w_in_range = 1'b1;
`endif

  always_ff @(posedge i_axi_clock) begin
    if (i_axi_reset) r_state <= IDLE;
    else             r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_rd_gnt)      w_next_state = RD;
        else if (w_wr_gnt) w_next_state = WR;
      end
      RD:      w_next_state = RD_DATA;
      RD_DATA: w_next_state = IDLE;
      WR:      w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Bank port is driven only during RD/WR and stays all-zero otherwise
  always_comb begin
    o_rd_gnt    = 1'b0;
    o_wr_gnt    = 1'b0;
    o_reg_en    = 1'b0;
    o_reg_we    = 1'b0;
    o_reg_addr  = '0;
    o_reg_wdata = '0;
    o_reg_wstrb = '0;
    case (r_state)
      IDLE: begin
        o_rd_gnt = w_rd_gnt;
        o_wr_gnt = w_wr_gnt;
      end
      RD: begin
        if (w_in_range) begin
          o_reg_en   = 1'b1;
          o_reg_addr = r_addr;
        end
      end
      WR: begin
        if (w_in_range) begin
          o_reg_en    = 1'b1;
          o_reg_we    = 1'b1;
          o_reg_addr  = r_addr;
          o_reg_wdata = r_wdata;
          o_reg_wstrb = r_wstrb;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_axi_clock) begin
    if (i_axi_reset) begin
      r_last_grant <= GNT_WR;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_err     <= 1'b0;
      r_wr_done    <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_done  <= 1'b0;
      r_wr_err   <= 1'b0;
      if (w_rd_gnt) begin
        r_addr       <= i_rd_addr;
        r_last_grant <= GNT_RD;
      end else if (w_wr_gnt) begin
        r_addr       <= i_wr_addr;
        r_wdata      <= i_wr_data;
        r_wstrb      <= i_wr_strb;
        r_last_grant <= GNT_WR;
      end
      if (r_state == RD_DATA) begin
        r_rd_data  <= w_in_range ? i_reg_rdata : '0;
        r_rd_err   <= !w_in_range;
        r_rd_valid <= 1'b1;
      end
      if (r_state == WR) begin
        r_wr_done <= 1'b1;
        r_wr_err  <= !w_in_range;
      end
    end
  end

  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_valid;
  assign o_rd_err        = r_rd_err;
  assign o_wr_done       = r_wr_done;
  assign o_wr_err        = r_wr_err;

endmodule

// File: tb/tb_s_axi4l_regbank_arbiter.sv
// Directed bench for s_axi4l_regbank_arbiter with a small strobe-aware bank
// model; expectations follow S_AXI4L_ARB_RANGE_CHECK_EN when it is defined.
module tb_s_axi4l_regbank_arbiter;

  localparam int NUM_REGS_TB = 2;
`ifdef S_AXI4L_ARB_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        rdReq;
  logic [3:0]  rdAddr;
  logic        rdGnt;
  logic [31:0] rdData;
  logic        rdValid;
  logic        rdErr;
  logic        wrReq;
  logic [3:0]  wrAddr;
  logic [31:0] wrData;
  logic [3:0]  wrStrb;
  logic        wrGnt;
  logic        wrDone;
  logic        wrErr;
  logic        regEn;
  logic        regWe;
  logic [3:0]  regAddr;
  logic [31:0] regWdata;
  logic [3:0]  regWstrb;
  logic [31:0] bankRdata;

  logic [31:0] mem [4] = '{32'hA5A50000, 32'hDEADBEEF, 32'h22220000, 32'h0BADF00D};

  int checks = 0;
  int errors = 0;

  s_axi4l_regbank_arbiter #(
    .AXI_DATA_WIDTH (32),
    .AXI_ADDR_WIDTH (4),
    .AXI_STRB_WIDTH (4),
    .NUM_REGS       (NUM_REGS_TB)
  ) dut (
    .i_axi_clock     (clk),
    .i_axi_reset     (rst),
    .i_rd_req        (rdReq),
    .i_rd_addr       (rdAddr),
    .o_rd_gnt        (rdGnt),
    .o_rd_data       (rdData),
    .o_rd_data_valid (rdValid),
    .o_rd_err        (rdErr),
    .i_wr_req        (wrReq),
    .i_wr_addr       (wrAddr),
    .i_wr_data       (wrData),
    .i_wr_strb       (wrStrb),
    .o_wr_gnt        (wrGnt),
    .o_wr_done       (wrDone),
    .o_wr_err        (wrErr),
    .o_reg_en        (regEn),
    .o_reg_we        (regWe),
    .o_reg_addr      (regAddr),
    .o_reg_wdata     (regWdata),
    .o_reg_wstrb     (regWstrb),
    .i_reg_rdata     (bankRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: read data appears the cycle after a read strobe, junk otherwise
  always @(posedge clk) begin
    if (regEn && !regWe) bankRdata <= mem[regAddr[3:2]];
    else                 bankRdata <= 32'hBAD0BAD0;
    if (regEn && regWe)
      for (int b = 0; b < 4; b++)
        if (regWstrb[b]) mem[regAddr[3:2]][8*b +: 8] <= regWdata[8*b +: 8];
  end

  function automatic bit outOfRange(input logic [3:0] addr);
    return RANGE_EN && (int'(addr[3:2]) >= NUM_REGS_TB);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({rdGnt, wrGnt, rdValid, rdErr, wrDone, wrErr, regEn, regWe} !== 8'h00) begin errors++; $display("[TB] FAIL reset_flags: got %b want 00000000", {rdGnt, wrGnt, rdValid, rdErr, wrDone, wrErr, regEn, regWe}); end
    checks++; if ({regAddr, regWdata, regWstrb} !== 40'h0) begin errors++; $display("[TB] FAIL reset_bank: got %h want 0", {regAddr, regWdata, regWstrb}); end
    checks++; if (rdData !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h want 00000000", rdData); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({rdGnt, wrGnt, regEn} !== 3'b000) begin errors++; $display("[TB] FAIL reset_idle: got %b want 000", {rdGnt, wrGnt, regEn}); end
  endtask

  task automatic test_read();
    @(negedge clk);
    rdReq = 1'b1; rdAddr = 4'h4;
    #1;
    checks++; if ({rdGnt, wrGnt, regEn} !== 3'b100) begin errors++; $display("[TB] FAIL read_gnt: got %b want 100", {rdGnt, wrGnt, regEn}); end
    @(negedge clk);
    rdReq = 1'b0;
    #1;
    checks++; if ({regEn, regWe, regAddr, rdGnt} !== {1'b1, 1'b0, 4'h4, 1'b0}) begin errors++; $display("[TB] FAIL read_strobe: got en=%b we=%b addr=%h gnt=%b want 1 0 4 0", regEn, regWe, regAddr, rdGnt); end
    @(negedge clk);
    #1;
    checks++; if ({regEn, rdValid} !== 2'b00) begin errors++; $display("[TB] FAIL read_wait: got en=%b valid=%b want 0 0", regEn, rdValid); end
    @(negedge clk);
    #1;
    checks++; if ({rdValid, rdErr, rdData} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL read_data: got valid=%b err=%b data=%h want 1 0 deadbeef", rdValid, rdErr, rdData); end
    @(negedge clk);
    #1;
    checks++; if ({rdValid, rdData} !== {1'b0, 32'hDEADBEEF}) begin errors++; $display("[TB] FAIL read_hold: got valid=%b data=%h want 0 deadbeef", rdValid, rdData); end
  endtask

  task automatic test_write();
    bit oor = outOfRange(4'h8);
    @(negedge clk);
    wrReq = 1'b1; wrAddr = 4'h8; wrData = 32'h12345678; wrStrb = 4'hF;
    #1;
    checks++; if ({rdGnt, wrGnt} !== 2'b01) begin errors++; $display("[TB] FAIL write_gnt: got %b want 01", {rdGnt, wrGnt}); end
    @(negedge clk);
    wrReq = 1'b0;
    #1;
    checks++;
    if (oor) begin
      if (regEn !== 1'b0) begin errors++; $display("[TB] FAIL write_strobe_oor: got en=%b want 0", regEn); end
    end else if ({regEn, regWe, regAddr, regWdata, regWstrb} !== {1'b1, 1'b1, 4'h8, 32'h12345678, 4'hF}) begin
      errors++; $display("[TB] FAIL write_strobe: got en=%b we=%b addr=%h data=%h strb=%h want 1 1 8 12345678 f", regEn, regWe, regAddr, regWdata, regWstrb);
    end
    @(negedge clk);
    #1;
    checks++; if ({wrDone, wrErr, regEn} !== {1'b1, oor, 1'b0}) begin errors++; $display("[TB] FAIL write_done: got done=%b err=%b en=%b want 1 %b 0", wrDone, wrErr, regEn, oor); end
    checks++; if (mem[2] !== (oor ? 32'h22220000 : 32'h12345678)) begin errors++; $display("[TB] FAIL write_mem: got %h want %h", mem[2], oor ? 32'h22220000 : 32'h12345678); end
    @(negedge clk);
    #1;
    checks++; if (wrDone !== 1'b0) begin errors++; $display("[TB] FAIL write_done_pulse: got %b want 0", wrDone); end
  endtask

  task automatic test_range();
    bit oor = outOfRange(4'hC);
    int enSeen = 0;
    @(negedge clk);
    rdReq = 1'b1; rdAddr = 4'hC;
    #1;
    checks++; if (rdGnt !== 1'b1) begin errors++; $display("[TB] FAIL range_gnt: got %b want 1", rdGnt); end
    @(negedge clk);
    rdReq = 1'b0;
    #1;
    if (regEn === 1'b1) enSeen++;
    checks++; if (regAddr !== (oor ? 4'h0 : 4'hC)) begin errors++; $display("[TB] FAIL range_addr: got %h want %h", regAddr, oor ? 4'h0 : 4'hC); end
    @(negedge clk);
    #1;
    if (regEn === 1'b1) enSeen++;
    @(negedge clk);
    #1;
    if (regEn === 1'b1) enSeen++;
    checks++; if (enSeen != (oor ? 0 : 1)) begin errors++; $display("[TB] FAIL range_en_count: got %0d want %0d", enSeen, oor ? 0 : 1); end
    checks++; if ({rdValid, rdErr, rdData} !== {1'b1, oor, oor ? 32'h0 : 32'h0BADF00D}) begin errors++; $display("[TB] FAIL range_data: got valid=%b err=%b data=%h want 1 %b %h", rdValid, rdErr, rdData, oor, oor ? 32'h0 : 32'h0BADF00D); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    rdReq = 1'b1; rdAddr = 4'h4;
    #1;
    checks++; if (rdGnt !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_gnt: got %b want 1", rdGnt); end
    @(negedge clk);
    rdReq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({rdValid, rdErr, wrDone, regEn, rdGnt, rdData} !== {5'b00000, 32'h0}) begin errors++; $display("[TB] FAIL rstmid_clear: got valid=%b err=%b done=%b en=%b gnt=%b data=%h want all 0", rdValid, rdErr, wrDone, regEn, rdGnt, rdData); end
    @(negedge clk);
    #1;
    checks++; if (rdValid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_no_pulse: got %b want 0", rdValid); end
    rdReq = 1'b1; rdAddr = 4'h0;
    #1;
    checks++; if (rdGnt !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_regnt: got %b want 1", rdGnt); end
    @(negedge clk);
    rdReq = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({rdValid, rdData} !== {1'b1, 32'hA5A50000}) begin errors++; $display("[TB] FAIL rstmid_reread: got valid=%b data=%h want 1 a5a50000", rdValid, rdData); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    wrReq = 1'b1; wrAddr = 4'h0; wrData = 32'h11111111; wrStrb = 4'hF;
    #1;
    checks++; if (wrGnt !== 1'b1) begin errors++; $display("[TB] FAIL b2b_gnt1: got %b want 1", wrGnt); end
    @(negedge clk);
    wrAddr = 4'h4; wrData = 32'h22222222; wrStrb = 4'h3;
    #1;
    checks++; if ({regEn, regWe, regAddr, regWdata, regWstrb, wrGnt} !== {1'b1, 1'b1, 4'h0, 32'h11111111, 4'hF, 1'b0}) begin errors++; $display("[TB] FAIL b2b_write1: got en=%b we=%b addr=%h data=%h strb=%h gnt=%b", regEn, regWe, regAddr, regWdata, regWstrb, wrGnt); end
    @(negedge clk);
    #1;
    checks++; if ({wrDone, wrGnt, regEn} !== 3'b110) begin errors++; $display("[TB] FAIL b2b_done_gnt: got done=%b gnt=%b en=%b want 1 1 0", wrDone, wrGnt, regEn); end
    @(negedge clk);
    wrReq = 1'b0;
    #1;
    checks++; if ({regEn, regWe, regAddr, regWdata, regWstrb, wrDone} !== {1'b1, 1'b1, 4'h4, 32'h22222222, 4'h3, 1'b0}) begin errors++; $display("[TB] FAIL b2b_write2: got en=%b we=%b addr=%h data=%h strb=%h done=%b", regEn, regWe, regAddr, regWdata, regWstrb, wrDone); end
    @(negedge clk);
    #1;
    checks++; if (wrDone !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %b want 1", wrDone); end
    checks++; if ({mem[0], mem[1]} !== {32'h11111111, 32'hDEAD2222}) begin errors++; $display("[TB] FAIL b2b_mem: got %h %h want 11111111 dead2222", mem[0], mem[1]); end
  endtask

  task automatic test_contention();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c == 0) begin
        rdReq = 1'b1; rdAddr = 4'h0;
        wrReq = 1'b1; wrAddr = 4'hC; wrData = 32'hCAFEF00D; wrStrb = 4'hF;
      end
      #1;
      checks++;
      if ({rdGnt, wrGnt} !== {(c == 0 || c == 5), (c == 3 || c == 8)}) begin
        errors++; $display("[TB] FAIL contention_cycle%0d: got rd=%b wr=%b want rd=%b wr=%b", c, rdGnt, wrGnt, (c == 0 || c == 5), (c == 3 || c == 8));
      end
    end
    @(negedge clk);
    rdReq = 1'b0; wrReq = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; rdReq = 1'b0; rdAddr = '0;
    wrReq = 1'b0; wrAddr = '0; wrData = '0; wrStrb = '0;
    test_reset();
    test_read();
    test_write();
    test_range();
    test_reset_mid();
    test_back_to_back();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
